// File: rtl/control_mult_fp_pkg.sv
// Shared constants, field widths and FSM state type for the binary32 multiplier.
package pkg_fp;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int SIG_W  = MANT_W + 1;
  localparam int PROD_W = 2 * SIG_W;

  localparam logic [EXP_W-1:0]  EXP_MAX   = 8'd255;
  localparam logic signed [9:0] BIAS      = 10'sd127;
  localparam logic [31:0]       QNAN      = 32'h7FC0_0000;
  localparam logic [4:0]        ITER_LAST = 5'd23;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MULT  = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/control_mult_fp_mult_mantisa_serie.sv
// Serial 24x24 shift-add multiplier: one partial product accumulated per step.
module mult_mantisa_serie
  import pkg_fp::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [SIG_W-1:0]  mcand,
  input  logic [SIG_W-1:0]  mplier,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] r_mcand;
  logic [SIG_W-1:0]  r_mplier;
  logic [PROD_W-1:0] r_prod;

  // Load clears the accumulator; each step adds the shifted multiplicand when the current multiplier bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (load) begin
      r_mcand  <= {{SIG_W{1'b0}}, mcand};
      r_mplier <= mplier;
      r_prod   <= '0;
    end else if (step) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign product = r_prod;

endmodule

// File: rtl/control_mult_fp.sv
// Sequential binary32 multiplier controller: operand capture, special-case screening,
// serial mantissa multiply, normalization (truncating) and packing with overflow/underflow flags.
module control_mult_fp
  import pkg_fp::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  state_t r_state;
  state_t w_state_next;

  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic signed [9:0] r_exp;
  logic [4:0]        r_count;
  logic [31:0]       r_result;
  logic              r_ovf;
  logic              r_unf;

  logic              w_load;
  logic              w_step;
  logic              w_sign;
  logic              w_special;
  logic [31:0]       w_special_val;
  logic signed [9:0] w_exp_sum;
  logic [PROD_W-1:0] w_prod;
  logic signed [9:0] w_exp_norm;
  logic [MANT_W-1:0] w_mant;
  logic [31:0]       w_packed;
  logic              w_ovf;
  logic              w_unf;

  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [MANT_W-1:0] w_ma, w_mb;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_ea = r_a[30:23];
  assign w_eb = r_b[30:23];
  assign w_ma = r_a[22:0];
  assign w_mb = r_b[22:0];

  // Operand classification and special-case result selection (NaN/inf*0 > inf > zero/denormal).
  always_comb begin
    w_sign        = r_a[31] ^ r_b[31];
    w_a_nan       = (w_ea == EXP_MAX) && (w_ma != '0);
    w_b_nan       = (w_eb == EXP_MAX) && (w_mb != '0);
    w_a_inf       = (w_ea == EXP_MAX) && (w_ma == '0);
    w_b_inf       = (w_eb == EXP_MAX) && (w_mb == '0);
    w_a_zero      = (w_ea == '0);
    w_b_zero      = (w_eb == '0);
    w_special     = 1'b1;
    w_special_val = {w_sign, 31'h0};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_special_val = QNAN;
    end else if (w_a_inf || w_b_inf) begin
      w_special_val = {w_sign, EXP_MAX, 23'h0};
    end else if (w_a_zero || w_b_zero) begin
      w_special_val = {w_sign, 31'h0};
    end else begin
      w_special = 1'b0;
    end
    w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;
  end

  // Normalize the raw product by its top bit and pack, saturating to inf or flushing to zero.
  always_comb begin
    w_exp_norm = r_exp;
    w_mant     = w_prod[45:23];
    if (w_prod[47]) begin
      w_exp_norm = r_exp + 10'sd1;
      w_mant     = w_prod[46:24];
    end
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    w_packed = {w_sign, w_exp_norm[7:0], w_mant};
    if (w_exp_norm >= 10'sd255) begin
      w_ovf    = 1'b1;
      w_packed = {w_sign, EXP_MAX, 23'h0};
    end else if (w_exp_norm <= 10'sd0) begin
      w_unf    = 1'b1;
      w_packed = {w_sign, 31'h0};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode plus multiplier load/step strobes and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    ready        = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_special) begin
          w_state_next = S_DONE;
        end else begin
          w_load       = 1'b1;
          w_state_next = S_MULT;
        end
      end
      S_MULT: begin
        w_step = 1'b1;
        if (r_count == ITER_LAST) w_state_next = S_NORM;
      end
      S_NORM:  w_state_next = S_DONE;
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath registers: operand capture, exponent, iteration count, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_exp    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
          end
        end
        S_CHECK: begin
          r_exp   <= w_exp_sum;
          r_count <= '0;
          if (w_special) r_result <= w_special_val;
        end
        S_MULT:  r_count <= r_count + 5'd1;
        S_NORM: begin
          r_result <= w_packed;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
        end
        default: ;
      endcase
    end
  end

  mult_mantisa_serie u_mant (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .step    (w_step),
    .mcand   ({1'b1, w_ma}),
    .mplier  ({1'b1, w_mb}),
    .product (w_prod)
  );

  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_control_mult_fp.sv
// Self-checking bench for control_mult_fp: directed cases, random operands, mid-run start and reset.
module tb_control_mult_fp;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int total;
  int bad;
  logic [31:0] prev_result;

  control_mult_fp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: value semantics of binary32 multiply with flush-to-zero and truncation.
  // Returns {is_special, overflow, underflow, result}.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e;
    longint unsigned sx, sy, p;
    logic s;
    logic [22:0] m;
    logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    x_nan  = (ex == 255) && (x[22:0] != 0);
    y_nan  = (ey == 255) && (y[22:0] != 0);
    x_inf  = (ex == 255) && (x[22:0] == 0);
    y_inf  = (ey == 255) && (y[22:0] == 0);
    x_zero = (ex == 0);
    y_zero = (ey == 0);
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) return {3'b100, 32'h7FC00000};
    if (x_inf || y_inf) return {3'b100, s, 8'hFF, 23'h0};
    if (x_zero || y_zero) return {3'b100, s, 31'h0};
    sx = 64'h800000 + 64'(x[22:0]);
    sy = 64'h800000 + 64'(y[22:0]);
    p  = sx * sy;
    e  = ex + ey - 127;
    if (p >= 64'h8000_0000_0000) begin
      e = e + 1;
      m = 23'((p / 64'h100_0000) % 64'h80_0000);
    end else begin
      m = 23'((p / 64'h80_0000) % 64'h80_0000);
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, s, 31'h0};
    return {3'b000, s, 8'(e), m};
  endfunction

  // One operation: optional stray start at cycle inj (0 = none), then check latency, result, flags.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input int inj);
    logic [34:0] m;
    int n;
    int lat;
    bit seen;
    bit busy_ok;
    m   = model(ta, tb);
    lat = m[34] ? 2 : 27;
    @(negedge clk);
    check("ready_idle", ready, 1);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta; b = ~tb;
    check("flags_clr", {overflow, underflow}, 0);
    check("result_hold", result, prev_result);
    n = 1; seen = 0; busy_ok = 1;
    while (n < 40 && !seen) begin
      if (done) begin
        seen = 1;
      end else begin
        if (ready) busy_ok = 0;
        if (n == inj) begin
          start = 1'b1;
          a = 32'h3F800000; b = 32'h3F800000;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n++;
      end
    end
    check("done_seen", seen, 1);
    check("busy_ready", busy_ok, 1);
    if (seen) begin
      check("latency", n, lat);
      check("result", result, m[31:0]);
      check("ovf_unf", {overflow, underflow}, m[33:32]);
      $display("op a=%h b=%h -> result=%h ovf=%0d unf=%0d lat=%0d", ta, tb, result, overflow, underflow, n);
    end
    prev_result = m[31:0];
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("ready_back", ready, 1);
    check("flags_held", {overflow, underflow}, m[33:32]);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit quiet;
    total = 0; bad = 0; prev_result = 32'h0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {overflow, underflow}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h40000000, 32'h40400000, 0);
    check("t_2x3", prev_result, 32'h40C00000);
    do_op(32'hBFC00000, 32'h40000000, 0);
    check("t_m15x2", prev_result, 32'hC0400000);
    do_op(32'h00000000, 32'hC0A00000, 0);
    do_op(32'h7F800000, 32'h00000000, 0);
    do_op(32'h7F000000, 32'h7F000000, 0);
    do_op(32'h00800000, 32'h00800000, 0);
    do_op(32'h7FC12345, 32'h3F800000, 0);
    do_op(32'hFF800000, 32'h40000000, 0);

    // Stray start during MULT must be ignored.
    do_op(32'h40000000, 32'h40400000, 6);

    // Random operands, mostly normal with occasional zero/inf/NaN exponents.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      if ($urandom_range(0, 7) == 0) rb[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      do_op(ra, rb, 0);
    end

    // Reset asserted during MULT aborts with no done pulse.
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_flags", {overflow, underflow}, 0);
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) quiet = 0;
    end
    check("abort_no_done", quiet, 1);
    @(negedge clk);
    rst_n = 1'b1;
    prev_result = 32'h0;
    do_op(32'h40000000, 32'h40400000, 0);
    check("t_after_rst", prev_result, 32'h40C00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_mult_fp.md
# control_mult_fp

Sequential IEEE-754 single-precision multiplier controller. Accepts two operands through a start/ready handshake, sequences sign XOR, exponent add/bias removal, a 24-iteration shift-add mantissa multiply, normalization and packing, then presents the result with a one-cycle done pulse. Sits between the operand register bank and the result bus of the FP unit, and owns the shared mantissa datapath.

## Interface
- No parameters; format fixed to binary32 (1/8/23).
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  request; accepted only on a clk edge where ready=1
- a  in  32  operand A, captured at acceptance
- b  in  32  operand B, captured at acceptance
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  32  packed product, held until next done
- overflow  out  1  valid with done, held until next acceptance
- underflow  out  1  valid with done, held until next acceptance

## Operation
- States: IDLE, CHECK, MULT, NORM, DONE. IDLE->CHECK on start. CHECK->DONE for special cases, else ->MULT. MULT stays 24 cycles (iteration counter 0..23) ->NORM->DONE->IDLE.
- start while ready=0 ignored; operands not re-captured.
- Sign: s = a[31] ^ b[31], all cases including special.
- Special cases (CHECK, priority order): either operand exp=255 with mant!=0, or inf times zero -> 32'h7FC00000; either exp=255 -> {s,8'hFF,23'h0}; either exp=0 (zero or denormal, flushed) -> {s,31'h0}. No flags set on special cases.
- Exponent: 10-bit signed e = ea + eb - 127.
- Mantissa: 48-bit p = {1,ma} * {1,mb}, shift-add, one partial product per MULT cycle.
- NORM: if p[47]=1 -> m = p[46:24], e = e+1; else m = p[45:23]. Rounding is truncation.
- Pack: e >= 255 -> {s,8'hFF,23'h0}, overflow=1; e <= 0 -> {s,31'h0}, underflow=1; else {s,e[7:0],m}.

## Timing
- Reset values: state IDLE, ready=1, done=0, result=0, overflow=0, underflow=0, counter 0, product 0.
- Start accepted at edge k: CHECK in cycle k+1, MULT k+2..k+25, NORM k+26, DONE k+27 (done=1, result/flags updated same cycle). Normal latency 27 cycles.
- Special-case latency: DONE in cycle k+2.
- ready returns high the cycle after DONE; back-to-back throughput one operation per 28 cycles (normal).
- Flags cleared at acceptance; result keeps old value until new done.
- rst_n low mid-operation: immediate abort to IDLE, all outputs to reset values, no done for the aborted operation.

## Structure
- Package pkg_fp: BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, state enum, field-width constants.
- Sub-module mult_mantisa_serie: 24x24 shift-add unit with load/step inputs and 48-bit product; controller FSM drives it and counts iterations.

## Test plan
- 0x40000000 x 0x40400000 (2.0 x 3.0) -> result 0x40C00000, flags 0, done exactly 27 cycles after start edge.
- 0xBFC00000 x 0x40000000 (-1.5 x 2.0) -> 0xC0400000, flags 0.
- 0x00000000 x 0xC0A00000 -> 0x80000000, done at cycle k+2; 0x7F800000 x 0x00000000 -> 0x7FC00000.
- 0x7F000000 x 0x7F000000 -> 0x7F800000, overflow=1; 0x00800000 x 0x00800000 -> 0x00000000, underflow=1.
- start pulsed with new operands during MULT -> ignored, first result unchanged, ready stays 0 until after DONE.
- rst_n asserted during MULT -> ready=1 and done=0 immediately, no done pulse; next operation 2.0 x 3.0 completes correctly.
